// File: rtl/mul_pkg.sv
// Shared types, latency constant and sign helpers for the RV32M multiply group.
// Also used by the decode and hazard logic.
package mul_pkg;

   localparam int unsigned MUL_XLEN    = 32;
   localparam int unsigned MUL_LATENCY = 33;

   typedef enum logic [1:0] {
      MUL    = 2'b00,
      MULH   = 2'b01,
      MULHSU = 2'b10,
      MULHU  = 2'b11
   } mul_op_e;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } mul_state_e;

   function automatic logic op1_is_signed(mul_op_e op);
      return (op == MULH) || (op == MULHSU);
   endfunction

   function automatic logic op2_is_signed(mul_op_e op);
      return op == MULH;
   endfunction

   // 0x80000000 maps to itself, which is the correct unsigned magnitude 2^31.
   function automatic logic [MUL_XLEN-1:0] magnitude(logic [MUL_XLEN-1:0] v, logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*MUL_XLEN-1:0] cond_negate(logic [2*MUL_XLEN-1:0] v, logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/iterative_mul_unit.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU with fixed 33-cycle latency.
// Operates on operand magnitudes and applies the product sign in a final fix-up cycle.
module iterative_mul_unit
   import mul_pkg::*;
#(
   parameter int unsigned XLEN = MUL_XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   input  logic [1:0]      mul_opcode,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result_multiply
);

   localparam int unsigned CNT_W = $clog2(XLEN);

   mul_state_e        state_q, state_d;
   mul_op_e           op_q, op_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0]   mplier_q, mplier_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic [XLEN-1:0]   result_q, result_d;

   mul_op_e           op_in;
   logic              sign1, sign2;
   logic [XLEN:0]     sum;
   logic [2*XLEN-1:0] product;

   always_comb begin
      op_in   = mul_op_e'(mul_opcode);
      sign1   = op1_is_signed(op_in) & operand1[XLEN-1];
      sign2   = op2_is_signed(op_in) & operand2[XLEN-1];
      sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (mcand_q[0] ? mplier_q : '0)};
      product = cond_negate(acc_q, neg_q);

      state_d  = state_q;
      op_d     = op_q;
      neg_d    = neg_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      result_d = result_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = CALC;
               op_d     = op_in;
               neg_d    = sign1 ^ sign2;
               mcand_d  = magnitude(operand1, sign1);
               mplier_d = magnitude(operand2, sign2);
               acc_d    = '0;
               cnt_d    = '0;
            end
         end
         CALC: begin
            // Add into the upper half, then shift the 65-bit {carry, acc} right by one.
            acc_d   = {sum, acc_q[XLEN-1:1]};
            mcand_d = mcand_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            result_d = (op_q == MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
            done_d   = 1'b1;
            state_d  = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Flush overrides everything, including acceptance of a start in IDLE.
      if (flush) begin
         state_d  = IDLE;
         done_d   = 1'b0;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= MUL;
         neg_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign busy            = (state_q != IDLE);
   assign done            = done_q;
   assign result_multiply = result_q;

endmodule
